// File: rtl/scroll_pkg.sv
// Shared types and constants for the rotating-display scroll sequencer.
package scroll_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/scroll_prescaler.sv
// Speed-scaled prescaler: counts while enabled and flags the terminal count of DIV >> speed.
module scroll_prescaler #(
    parameter int DIV = 50_000_000,
    parameter int CW  = $clog2(DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       done
);

    logic [CW-1:0] cnt;
    logic [31:0]   term;

    // >= so that a speed increase past the current count fires on the next edge
    always_comb begin
        term = 32'(DIV >> speed) - 32'd1;
        done = en && (32'(cnt) >= term);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || !en || done)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/scroll_controller.sv
// Rotation-select sequencer for the four-digit HEX display: run/pause, single-step,
// direction and four speed settings driving shifter_decoder.a.
module scroll_controller
    import scroll_pkg::*;
#(
    parameter int DIV = 50_000_000,
    parameter int CW  = $clog2(DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_btn,
    input  logic       step_btn,
    input  logic       dir,
    input  logic [1:0] speed,
    output logic [1:0] shift,
    output logic       tick,
    output logic       running
);

    state_t state, state_nxt;
    logic   run_q, step_q;
    logic   run_e, step_e;
    logic   done, advance;

    assign run_e   = run_btn & ~run_q;
    assign step_e  = step_btn & ~step_q;
    assign running = (state == ST_RUN);

    // Every run/pause transition restarts the period from zero
    scroll_prescaler #(
        .DIV (DIV),
        .CW  (CW)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_RUN),
        .clr   (run_e),
        .speed (speed),
        .done  (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_RUN;
            run_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            run_q  <= run_btn;
            step_q <= step_btn;
        end
    end

    // A run/pause key press always takes priority over a pending advance
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            ST_RUN: begin
                if (run_e)
                    state_nxt = ST_PAUSED;
                else if (done)
                    advance = 1'b1;
            end
            ST_PAUSED: begin
                if (run_e)
                    state_nxt = ST_RUN;
                else if (step_e)
                    advance = 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift <= 2'd0;
            tick  <= 1'b0;
        end else begin
            tick <= advance;
            if (advance)
                shift <= (dir == DIR_REV) ? shift - 2'd1 : shift + 2'd1;
        end
    end

endmodule

// File: tb/tb_scroll_controller.sv
// Directed self-checking bench for scroll_controller with DIV=16.
module tb_scroll_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_btn;
    logic       step_btn;
    logic       dir;
    logic [1:0] speed;
    logic [1:0] shift;
    logic       tick;
    logic       running;

    int checks = 0;
    int errors = 0;

    scroll_controller #(.DIV(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .run_btn  (run_btn),
        .step_btn (step_btn),
        .dir      (dir),
        .speed    (speed),
        .shift    (shift),
        .tick     (tick),
        .running  (running)
    );

    always #5 clk = ~clk;

    // Counts negedges until tick is seen; n = -1 when the bound expires.
    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < max);
        if (!tick) n = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1; run_btn = 1'b0; step_btn = 1'b0; dir = 1'b0; speed = 2'd0;
        #1;
        checks++;
        if (shift !== 2'd0 || tick !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: shift=%0d tick=%0b running=%0b, want 0/0/1", shift, tick, running);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_forward;
        int n;
        for (int i = 0; i < 4; i++) begin
            wait_tick(40, n);
            checks++;
            if (n !== 16 || shift !== 2'((i + 1) % 4)) begin
                errors++;
                $display("FAIL fwd_tick%0d: gap=%0d shift=%0d, want 16/%0d", i, n, shift, (i + 1) % 4);
            end
        end
        @(negedge clk);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: tick=%0b, want 0", tick);
        end
        wait_tick(40, n);   // realign on a tick (shift 0 -> 1)
        checks++;
        if (n !== 15 || shift !== 2'd1) begin
            errors++;
            $display("FAIL fwd_realign: gap=%0d shift=%0d, want 15/1", n, shift);
        end
    endtask

    task automatic test_reverse;
        int n;
        logic [1:0] exp_shift [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
        speed = 2'd3; dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick(10, n);
            checks++;
            if (n !== 2 || shift !== exp_shift[i]) begin
                errors++;
                $display("FAIL rev_tick%0d: gap=%0d shift=%0d, want 2/%0d", i, n, shift, exp_shift[i]);
            end
        end
    endtask

    task automatic test_pause_step;
        int cnt;
        speed = 2'd0; dir = 1'b0; run_btn = 1'b1;
        @(negedge clk);
        run_btn = 1'b0;
        checks++;
        if (running !== 1'b0 || shift !== 2'd1) begin
            errors++;
            $display("FAIL pause: running=%0b shift=%0d, want 0/1", running, shift);
        end
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        checks++;
        if (cnt !== 0 || shift !== 2'd1) begin
            errors++;
            $display("FAIL paused_idle: ticks=%0d shift=%0d, want 0/1", cnt, shift);
        end
        for (int i = 0; i < 3; i++) begin
            step_btn = 1'b1;
            @(negedge clk);
            step_btn = 1'b0;
            checks++;
            if (tick !== 1'b1 || shift !== 2'((i + 2) % 4)) begin
                errors++;
                $display("FAIL step%0d: tick=%0b shift=%0d, want 1/%0d", i, tick, shift, (i + 2) % 4);
            end
            @(negedge clk);
        end
        step_btn = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        step_btn = 1'b0;
        checks++;
        if (cnt !== 1 || shift !== 2'd1) begin
            errors++;
            $display("FAIL step_held: ticks=%0d shift=%0d, want 1/1", cnt, shift);
        end
    endtask

    task automatic test_run_step_same;
        int n;
        @(negedge clk);
        run_btn = 1'b1; step_btn = 1'b1;
        @(negedge clk);
        run_btn = 1'b0; step_btn = 1'b0;
        checks++;
        if (running !== 1'b1 || shift !== 2'd1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL run_step_same: running=%0b shift=%0d tick=%0b, want 1/1/0", running, shift, tick);
        end
        wait_tick(40, n);
        checks++;
        if (n !== 16 || shift !== 2'd2) begin
            errors++;
            $display("FAIL resume_period: gap=%0d shift=%0d, want 16/2", n, shift);
        end
    endtask

    task automatic test_speed_change;
        int n;
        repeat (10) @(negedge clk);
        speed = 2'd3;
        wait_tick(5, n);
        checks++;
        if (n !== 1 || shift !== 2'd3) begin
            errors++;
            $display("FAIL speed_jump: gap=%0d shift=%0d, want 1/3", n, shift);
        end
        wait_tick(10, n);
        checks++;
        if (n !== 2 || shift !== 2'd0) begin
            errors++;
            $display("FAIL speed_period: gap=%0d shift=%0d, want 2/0", n, shift);
        end
    endtask

    task automatic test_reset_paused;
        int n;
        speed = 2'd0; dir = 1'b1; run_btn = 1'b1;
        @(negedge clk);
        run_btn = 1'b0; step_btn = 1'b1;
        @(negedge clk);
        step_btn = 1'b0;
        @(negedge clk);
        // reverse single step from 0 lands on 3; one more lands on 2
        step_btn = 1'b1;
        @(negedge clk);
        step_btn = 1'b0;
        @(negedge clk);
        checks++;
        if (shift !== 2'd2 || running !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: shift=%0d running=%0b, want 2/0", shift, running);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (shift !== 2'd0 || running !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: shift=%0d running=%0b tick=%0b, want 0/1/0", shift, running, tick);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0; dir = 1'b0;
        wait_tick(40, n);
        checks++;
        if (n !== 16 || shift !== 2'd1) begin
            errors++;
            $display("FAIL post_reset: gap=%0d shift=%0d, want 16/1", n, shift);
        end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_reverse;
        test_pause_step;
        test_run_step_same;
        test_speed_change;
        test_reset_paused;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
